// File: rtl/memory_access_stage.sv
// memory_access_stage: sits between the EX/MEM and MEM/WB buffers.
// Drives the data-memory port, owns the stack pointer and the output-port
// register, and registers the values the write-back stage needs.
// Optional build macro: STACK_GUARD_EN blocks pushes below STACK_LIMIT and
// pops from an empty stack, reporting them on stack_err.
module memory_access_stage #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] SP_RESET    = 16'h07FF,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 16'h0400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic              in_port_in,
    input  logic              out_port_in,
    input  logic              wb_in,
    input  logic [2:0]        dest_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [DATA_W-1:0] in_port_data,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              wb_out,
    output logic              mem_to_reg_out,
    output logic [2:0]        dest_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] sp,
    output logic              stack_err
);

    localparam logic [DATA_W-1:0] ONE = 1;

    logic              push_req;
    logic              pop_req;
    logic              both_err;
    logic              overflow;
    logic              underflow;
    logic              push_ok;
    logic              pop_ok;
    logic              illegal;
    logic              plain_op;
    logic [DATA_W-1:0] sp_inc;
    logic [DATA_W-1:0] sp_dec;

    assign sp_inc = sp + ONE;
    assign sp_dec = sp - ONE;

    // Classify the stack request; simultaneous push and pop is always illegal.
    always_comb begin
        push_req  = push_in & ~pop_in;
        pop_req   = pop_in & ~push_in;
        both_err  = push_in & pop_in;
`ifdef STACK_GUARD_EN
        overflow  = push_req & (sp < STACK_LIMIT);
        underflow = pop_req & (sp == SP_RESET);
`else
        overflow  = 1'b0;
        underflow = 1'b0;
`endif
        push_ok   = push_req & ~overflow;
        pop_ok    = pop_req & ~underflow;
        illegal   = both_err | overflow | underflow;
        plain_op  = ~push_in & ~pop_in;
    end

    // Memory port: stack ops take priority over plain loads/stores, a store
    // beats a load when both are requested.
    always_comb begin
        mem_wdata = store_data_in;
        mem_addr  = alu_result_in;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (push_req) begin
            mem_addr = sp;
            mem_we   = push_ok;
        end else if (pop_req) begin
            mem_addr = sp_inc;
            mem_re   = pop_ok;
        end else if (plain_op) begin
            mem_we   = mem_write_in;
            mem_re   = mem_read_in & ~mem_write_in;
        end
    end

    // Stack pointer: post-decrement on push, pre-increment on pop, wraps freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= SP_RESET;
        end else if (push_ok) begin
            sp <= sp_dec;
        end else if (pop_ok) begin
            sp <= sp_inc;
        end
    end

    // MEM/WB buffer plus error pulse; illegal stack ops suppress write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_out         <= 1'b0;
            mem_to_reg_out <= 1'b0;
            dest_out       <= 3'd0;
            result_out     <= '0;
            stack_err      <= 1'b0;
        end else begin
            wb_out         <= wb_in & ~illegal;
            mem_to_reg_out <= (mem_read_in | pop_in) & ~illegal;
            dest_out       <= dest_in;
            result_out     <= in_port_in ? in_port_data : alu_result_in;
            stack_err      <= illegal;
        end
    end

    // Output-port register loads only when requested, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= '0;
        end else if (out_port_in) begin
            out_port <= store_data_in;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: directed vectors, scoreboard queues
// filled by the driver and drained by independent monitors.
// Handshake: every cycle the driver applies one instruction at the falling
// edge and pushes one combinational and one registered expectation; the
// combinational monitor checks 2 ns after that falling edge, the registered
// monitor checks 1 ns after the following rising edge.
module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic        mem_read_in, mem_write_in, push_in, pop_in;
  logic        in_port_in, out_port_in, wb_in;
  logic [2:0]  dest_in;
  logic [15:0] alu_result_in, store_data_in, in_port_data;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic        wb_out, mem_to_reg_out;
  logic [2:0]  dest_out;
  logic [15:0] result_out, out_port, sp;
  logic        stack_err;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
  } comb_t;

  typedef struct packed {
    logic        wb;
    logic        m2r;
    logic [2:0]  dest;
    logic [15:0] result;
    logic [15:0] outp;
    logic [15:0] sp_v;
    logic        err;
  } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  memory_access_stage dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .push_in(push_in), .pop_in(pop_in),
    .in_port_in(in_port_in), .out_port_in(out_port_in), .wb_in(wb_in),
    .dest_in(dest_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .in_port_data(in_port_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .wb_out(wb_out), .mem_to_reg_out(mem_to_reg_out), .dest_out(dest_out),
    .result_out(result_out), .out_port(out_port), .sp(sp), .stack_err(stack_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    mem_read_in = 0; mem_write_in = 0; push_in = 0; pop_in = 0;
    in_port_in = 0; out_port_in = 0; wb_in = 0; dest_in = 0;
    alu_result_in = 0; store_data_in = 0; in_port_data = 0;
  endtask

  task automatic exp_c(input logic [15:0] addr, input logic [15:0] wdata,
                       input logic re, input logic we);
    comb_q.push_back('{addr: addr, wdata: wdata, re: re, we: we});
  endtask

  task automatic exp_r(input logic wb, input logic m2r, input logic [2:0] dest,
                       input logic [15:0] result, input logic [15:0] outp,
                       input logic [15:0] sp_v, input logic err);
    reg_q.push_back('{wb: wb, m2r: m2r, dest: dest, result: result,
                      outp: outp, sp_v: sp_v, err: err});
  endtask

  // combinational monitor
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        check("mem_addr", mem_addr, c.addr);
        check("mem_wdata", mem_wdata, c.wdata);
        check("mem_re", {15'd0, mem_re}, {15'd0, c.re});
        check("mem_we", {15'd0, mem_we}, {15'd0, c.we});
      end
    end
  end

  // registered monitor
  initial begin
    reg_t r;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        check("wb_out", {15'd0, wb_out}, {15'd0, r.wb});
        check("mem_to_reg_out", {15'd0, mem_to_reg_out}, {15'd0, r.m2r});
        check("dest_out", {13'd0, dest_out}, {13'd0, r.dest});
        check("result_out", result_out, r.result);
        check("out_port", out_port, r.outp);
        check("sp", sp, r.sp_v);
        check("stack_err", {15'd0, stack_err}, {15'd0, r.err});
      end
    end
  end

  // stimulus
  initial begin
    set_idle();
    reset = 1'b1;
    #2;
    check("rst_sp", sp, 16'h07FF);
    check("rst_out_port", out_port, 16'h0000);
    check("rst_wb_out", {15'd0, wb_out}, 16'h0000);
    check("rst_stack_err", {15'd0, stack_err}, 16'h0000);
    check("rst_result", result_out, 16'h0000);
    check("rst_m2r", {15'd0, mem_to_reg_out}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // push 0xBEEF, push 0x1234
    @(negedge clk); set_idle(); push_in = 1; store_data_in = 16'hBEEF;
    exp_c(16'h07FF, 16'hBEEF, 0, 1); exp_r(0, 0, 0, 16'h0000, 16'h0000, 16'h07FE, 0);
    @(negedge clk); set_idle(); push_in = 1; store_data_in = 16'h1234;
    exp_c(16'h07FE, 16'h1234, 0, 1); exp_r(0, 0, 0, 16'h0000, 16'h0000, 16'h07FD, 0);
    // pop twice
    @(negedge clk); set_idle(); pop_in = 1; wb_in = 1; dest_in = 2;
    exp_c(16'h07FE, 16'h0000, 1, 0); exp_r(1, 1, 2, 16'h0000, 16'h0000, 16'h07FE, 0);
    @(negedge clk); set_idle(); pop_in = 1; wb_in = 1; dest_in = 5;
    exp_c(16'h07FF, 16'h0000, 1, 0); exp_r(1, 1, 5, 16'h0000, 16'h0000, 16'h07FF, 0);
    // load
    @(negedge clk); set_idle(); mem_read_in = 1; alu_result_in = 16'h0010; wb_in = 1; dest_in = 3;
    exp_c(16'h0010, 16'h0000, 1, 0); exp_r(1, 1, 3, 16'h0010, 16'h0000, 16'h07FF, 0);
    // store
    @(negedge clk); set_idle(); mem_write_in = 1; alu_result_in = 16'h0020; store_data_in = 16'h00AA;
    exp_c(16'h0020, 16'h00AA, 0, 1); exp_r(0, 0, 0, 16'h0020, 16'h0000, 16'h07FF, 0);
    // store together with push: push wins
    @(negedge clk); set_idle(); mem_write_in = 1; push_in = 1; alu_result_in = 16'h0020; store_data_in = 16'h00AA;
    exp_c(16'h07FF, 16'h00AA, 0, 1); exp_r(0, 0, 0, 16'h0020, 16'h0000, 16'h07FE, 0);
    @(negedge clk); set_idle(); pop_in = 1;
    exp_c(16'h07FF, 16'h0000, 1, 0); exp_r(0, 1, 0, 16'h0000, 16'h0000, 16'h07FF, 0);
    // input port
    @(negedge clk); set_idle(); in_port_in = 1; in_port_data = 16'h5A5A; alu_result_in = 16'h1111; wb_in = 1; dest_in = 1;
    exp_c(16'h1111, 16'h0000, 0, 0); exp_r(1, 0, 1, 16'h5A5A, 16'h0000, 16'h07FF, 0);
    // output port load, then hold
    @(negedge clk); set_idle(); out_port_in = 1; store_data_in = 16'h0F0F;
    exp_c(16'h0000, 16'h0F0F, 0, 0); exp_r(0, 0, 0, 16'h0000, 16'h0F0F, 16'h07FF, 0);
    @(negedge clk); set_idle(); store_data_in = 16'h3333; alu_result_in = 16'h4444;
    exp_c(16'h4444, 16'h3333, 0, 0); exp_r(0, 0, 0, 16'h4444, 16'h0F0F, 16'h07FF, 0);
    // push and pop together: illegal, one-cycle error pulse
    @(negedge clk); set_idle(); push_in = 1; pop_in = 1; wb_in = 1; store_data_in = 16'h7777;
    exp_c(16'h0000, 16'h7777, 0, 0); exp_r(0, 0, 0, 16'h0000, 16'h0F0F, 16'h07FF, 1);
    @(negedge clk); set_idle();
    exp_c(16'h0000, 16'h0000, 0, 0); exp_r(0, 0, 0, 16'h0000, 16'h0F0F, 16'h07FF, 0);
    // load and store together: write wins
    @(negedge clk); set_idle(); mem_read_in = 1; mem_write_in = 1; alu_result_in = 16'h0030; store_data_in = 16'h0055;
    exp_c(16'h0030, 16'h0055, 0, 1); exp_r(0, 1, 0, 16'h0030, 16'h0F0F, 16'h07FF, 0);
    // pop from empty stack
    @(negedge clk); set_idle(); pop_in = 1; wb_in = 1; dest_in = 4;
`ifdef STACK_GUARD_EN
    exp_c(16'h0800, 16'h0000, 0, 0); exp_r(0, 0, 4, 16'h0000, 16'h0F0F, 16'h07FF, 1);
`else
    exp_c(16'h0800, 16'h0000, 1, 0); exp_r(1, 1, 4, 16'h0000, 16'h0F0F, 16'h0800, 0);
`endif

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (comb_q.size() > 0 || reg_q.size() > 0); i++) @(negedge clk);
    check("queue_drain", 16'(comb_q.size() + reg_q.size()), 16'd0);

    // reset in the middle of a push sequence
    @(negedge clk); set_idle(); push_in = 1; store_data_in = 16'hCAFE; wb_in = 1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_sp", sp, 16'h07FF);
    check("midrst_out_port", out_port, 16'h0000);
    check("midrst_wb_out", {15'd0, wb_out}, 16'h0000);
    @(negedge clk); set_idle();
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
Memory-access stage between the ALU stage and the write-back stage. It consumes the ALU result, store data and control signals from the EX/MEM buffer. It drives the data-memory interface and owns the stack pointer (push/pop) and the output-port register. It registers everything the write-back stage needs into the MEM/WB buffer.

Parameters:
DATA_W, 16, width of data, address and stack pointer
SP_RESET, 16'h07FF, stack pointer value after reset (empty stack; top of data memory)
STACK_LIMIT, 16'h0400, lowest legal stack address (used only with STACK_GUARD_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_read_in  in  1  load request from EX/MEM buffer
mem_write_in  in  1  store request from EX/MEM buffer
push_in  in  1  push store_data_in onto stack
pop_in  in  1  pop top of stack into destination register
in_port_in  in  1  write-back value comes from in_port_data
out_port_in  in  1  latch store_data_in into out_port
wb_in  in  1  register write-back enable
dest_in  in  3  destination register address
alu_result_in  in  DATA_W  ALU result / load-store address
store_data_in  in  DATA_W  store or push data (read_data2 path)
in_port_data  in  DATA_W  external input port
mem_addr  out  DATA_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
mem_re  out  1  data-memory read enable
mem_we  out  1  data-memory write enable
wb_out  out  1  MEM/WB: write-back enable
mem_to_reg_out  out  1  MEM/WB: select memory read data (load or pop)
dest_out  out  3  MEM/WB: destination register
result_out  out  DATA_W  MEM/WB: ALU result or in-port value
out_port  out  DATA_W  output-port register
sp  out  DATA_W  current stack pointer
stack_err  out  1  one-cycle pulse on illegal stack operation

Behaviour:
- Reset: sp=SP_RESET; out_port, result_out=0; wb_out, mem_to_reg_out, stack_err=0; dest_out=0. Reset applies immediately, mid-instruction included.
- Memory interface is combinational from current inputs and sp.
- Memory read is synchronous: data appears one cycle later, aligned with the MEM/WB outputs. The write-back stage muxes it using mem_to_reg_out.
- Priority: push/pop > mem_read/mem_write.
- Push: mem_addr=sp, mem_wdata=store_data_in, mem_we=1, mem_re=0. Next edge: sp<=sp-1 (post-decrement).
- Pop: mem_addr=sp+1, mem_re=1, mem_we=0. Next edge: sp<=sp+1 (pre-increment).
- push_in and pop_in both high: illegal. mem_re=mem_we=0, sp unchanged, stack_err=1 next cycle, wb_out forced 0.
- Plain load/store: mem_addr=alu_result_in[DATA_W-1:0]. mem_re=mem_read_in, mem_we=mem_write_in, mem_wdata=store_data_in. mem_read_in and mem_write_in both high: write wins, mem_re=0.
- Idle (no memory op): mem_re=mem_we=0; mem_addr=alu_result_in; mem_wdata=store_data_in.
- sp arithmetic is modulo 2^DATA_W: 16'h0000 push -> 16'hFFFF; 16'hFFFF pop -> 16'h0000.
- MEM/WB register, updated every edge (1-cycle latency):
  - wb_out<=wb_in; dest_out<=dest_in.
  - mem_to_reg_out<=(mem_read_in|pop_in) & ~illegal.
  - result_out<=in_port_in ? in_port_data : alu_result_in.
- out_port<=store_data_in on edges where out_port_in=1; otherwise it holds.
- No stall input; one instruction is accepted per cycle.

Optional Feature:
STACK_GUARD_EN
- Defined:
  - Push with sp<STACK_LIMIT (overflow) is blocked: mem_we=0, sp held, stack_err pulses, wb_out forced 0.
  - Pop with sp==SP_RESET (underflow) is blocked: mem_re=0, sp held, stack_err pulses, wb_out and mem_to_reg_out forced 0.
- Undefined: no bounds checks; sp wraps modulo 2^DATA_W; stack_err asserts only for simultaneous push/pop.

Test Plan:
- Reset -> sp=16'h07FF, out_port=0, wb_out=0, stack_err=0. Assert reset mid-push -> sp returns to 16'h07FF immediately.
- Push 16'hBEEF, then push 16'h1234 -> writes at 16'h07FF then 16'h07FE, sp=16'h07FD. Pop twice -> mem_addr 16'h07FE then 16'h07FF with mem_re=1, mem_to_reg_out=1, sp=16'h07FF.
- Load alu_result=16'h0010 with wb_in=1, dest=3 -> mem_addr=16'h0010, mem_re=1. Next cycle: wb_out=1, dest_out=3, mem_to_reg_out=1.
- Store alu_result=16'h0020, store_data=16'h00AA -> mem_we=1, mem_wdata=16'h00AA. Same cycle with push_in=1 -> push wins, mem_addr=sp.
- in_port_data=16'h5A5A with in_port_in=1 -> result_out=16'h5A5A next cycle. out_port_in=1 with store_data=16'h0F0F -> out_port=16'h0F0F, held afterwards.
- push_in=pop_in=1 -> no memory access, sp unchanged, stack_err=1 for exactly one cycle. With STACK_GUARD_EN, pop at sp=16'h07FF -> blocked, stack_err=1. Without STACK_GUARD_EN, same pop -> mem_addr=16'h0800, sp=16'h0800.
